wbs_decoder: RTL and testbench

Wishbone slave-side decoder sitting directly downstream of `wbm_arbiter`. It takes the single arbitrated master bus and steers each transaction to one of `NUM_SLAVES` slaves by address range. It rebases the address, returns the selected slave's data and ack, and terminates unmapped or hung accesses with a single-cycle error. Classic (non-pipelined) Wishbone only; one outstanding transaction at a time.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_timeout_counter.sv | 37 +++
 rtl/wbs_decoder.sv | 207 ++++++++++++++++++++
 tb/tb_wbs_decoder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone widths, decoder state encodings and clog2 helper
package wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 16;
    localparam int WB_SEL_W = 2;

    typedef enum logic [1:0] {
        WBS_DEC_IDLE = 2'd0,
        WBS_DEC_BUSY = 2'd1,
        WBS_DEC_DONE = 2'd2
    } wbs_dec_state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// rtl/wb_timeout_counter.sv - saturating cycle counter flagging TIMEOUT-1 reached
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_clear     : zero the count (takes priority over i_enable)
//   i_enable    : count one per cycle while high
//   o_expired   : high once the count has reached TIMEOUT-1; stays there until cleared
module wb_timeout_counter
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Stops at LIMIT so a long-hung slave can never wrap the count back to a
    // non-expired value.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count < LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count >= LIMIT);

endmodule

// File: rtl/wbs_decoder.sv
// rtl/wbs_decoder.sv - Wishbone address decoder steering one master to NUM_SLAVES slaves
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   wbm_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i : arbitrated master request
//   wbm_dat_o/ack_o/err_o           : registered master response
//   wbs_cyc_o/stb_o                 : one-hot per-slave cycle/strobe
//   wbs_we_o/sel_o/adr_o/dat_o      : shared slave request, address rebased to slave base
//   wbs_dat_i/ack_i/err_i           : per-slave responses (only the selected one is used)
//   timeout_o                       : one-cycle pulse when a hung slave is abandoned
module wbs_decoder
    import wb_pkg::*;
#(
    parameter int                        NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASE = {32'h30000, 32'h20000, 32'h10000, 32'h0},
    parameter logic [NUM_SLAVES*32-1:0]  SLAVE_HIGH = {32'h3FFFF, 32'h2FFFF, 32'h1FFFF, 32'hFFFF},
    parameter int                        TIMEOUT    = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wbm_cyc_i,
    input  logic                           wbm_stb_i,
    input  logic                           wbm_we_i,
    input  logic [WB_SEL_W-1:0]            wbm_sel_i,
    input  logic [WB_ADR_W-1:0]            wbm_adr_i,
    input  logic [WB_DAT_W-1:0]            wbm_dat_i,
    output logic [WB_DAT_W-1:0]            wbm_dat_o,
    output logic                           wbm_ack_o,
    output logic                           wbm_err_o,
    output logic [NUM_SLAVES-1:0]          wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]          wbs_stb_o,
    output logic                           wbs_we_o,
    output logic [WB_SEL_W-1:0]            wbs_sel_o,
    output logic [WB_ADR_W-1:0]            wbs_adr_o,
    output logic [WB_DAT_W-1:0]            wbs_dat_o,
    input  logic [NUM_SLAVES*WB_DAT_W-1:0] wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]          wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]          wbs_err_i,
    output logic                           timeout_o
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? clog2(NUM_SLAVES) : 1;

    wbs_dec_state_t          r_state, w_nxt_state;
    logic [IDX_W-1:0]        r_idx, w_nxt_idx;
    logic [NUM_SLAVES-1:0]   r_onehot, w_nxt_onehot;
    logic                    r_we, w_nxt_we;
    logic [WB_SEL_W-1:0]     r_sel, w_nxt_sel;
    logic [WB_ADR_W-1:0]     r_adr, w_nxt_adr;
    logic [WB_DAT_W-1:0]     r_wdat, w_nxt_wdat;
    logic [WB_DAT_W-1:0]     r_rdat, w_nxt_rdat;
    logic                    r_ack, w_nxt_ack;
    logic                    r_err, w_nxt_err;
    logic                    r_timeout, w_nxt_timeout;

    logic [NUM_SLAVES-1:0]   w_hit;
    logic                    w_any_hit;
    logic [IDX_W-1:0]        w_idx;
    logic [WB_ADR_W-1:0]     w_base;
    logic [WB_ADR_W-1:0]     w_rebased;
    logic                    w_sel_ack;
    logic                    w_sel_err;
    logic [WB_DAT_W-1:0]     w_sel_dat;
    logic                    w_cnt_clear;
    logic                    w_expired;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_range
            assign w_hit[gi] = (wbm_adr_i >= SLAVE_BASE[32*gi +: 32]) &&
                               (wbm_adr_i <= SLAVE_HIGH[32*gi +: 32]);
        end
    endgenerate

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        w_idx  = '0;
        w_base = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_idx  = IDX_W'(i);
                w_base = SLAVE_BASE[32*i +: 32];
            end
        end
    end

    assign w_any_hit = |w_hit;
    assign w_rebased = wbm_adr_i - w_base;

    assign w_sel_ack = wbs_ack_i[r_idx];
    assign w_sel_err = wbs_err_i[r_idx];
    assign w_sel_dat = wbs_dat_i[r_idx*WB_DAT_W +: WB_DAT_W];

    wb_timeout_counter #(
        .TIMEOUT   (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_cnt_clear),
        .i_enable  (r_state == WBS_DEC_BUSY),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= WBS_DEC_IDLE;
            r_idx     <= '0;
            r_onehot  <= '0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_adr     <= '0;
            r_wdat    <= '0;
            r_rdat    <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_idx     <= w_nxt_idx;
            r_onehot  <= w_nxt_onehot;
            r_we      <= w_nxt_we;
            r_sel     <= w_nxt_sel;
            r_adr     <= w_nxt_adr;
            r_wdat    <= w_nxt_wdat;
            r_rdat    <= w_nxt_rdat;
            r_ack     <= w_nxt_ack;
            r_err     <= w_nxt_err;
            r_timeout <= w_nxt_timeout;
        end
    end

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_idx     = r_idx;
        w_nxt_onehot  = r_onehot;
        w_nxt_we      = r_we;
        w_nxt_sel     = r_sel;
        w_nxt_adr     = r_adr;
        w_nxt_wdat    = r_wdat;
        w_nxt_rdat    = r_rdat;
        w_nxt_ack     = 1'b0;
        w_nxt_err     = 1'b0;
        w_nxt_timeout = 1'b0;
        w_cnt_clear   = 1'b0;

        case (r_state)
            WBS_DEC_IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    if (w_any_hit) begin
                        w_nxt_idx    = w_idx;
                        w_nxt_onehot = NUM_SLAVES'(1) << w_idx;
                        w_nxt_we     = wbm_we_i;
                        w_nxt_sel    = wbm_sel_i;
                        w_nxt_adr    = w_rebased;
                        w_nxt_wdat   = wbm_dat_i;
                        w_cnt_clear  = 1'b1;
                        w_nxt_state  = WBS_DEC_BUSY;
                    end else begin
                        w_nxt_err    = 1'b1;
                        w_nxt_state  = WBS_DEC_DONE;
                    end
                end
            end
            WBS_DEC_BUSY: begin
                // A master that has let go of the cycle gets no response at all.
                if (!wbm_cyc_i) begin
                    w_nxt_onehot  = '0;
                    w_nxt_state   = WBS_DEC_IDLE;
                end else if (w_sel_ack) begin
                    w_nxt_rdat    = w_sel_dat;
                    w_nxt_ack     = 1'b1;
                    w_nxt_onehot  = '0;
                    w_nxt_state   = WBS_DEC_DONE;
                end else if (w_sel_err) begin
                    w_nxt_err     = 1'b1;
                    w_nxt_onehot  = '0;
                    w_nxt_state   = WBS_DEC_DONE;
                end else if (w_expired) begin
                    w_nxt_err     = 1'b1;
                    w_nxt_timeout = 1'b1;
                    w_nxt_onehot  = '0;
                    w_nxt_state   = WBS_DEC_DONE;
                end
            end
            WBS_DEC_DONE: begin
                // Gives a registered master one cycle to drop stb after the response.
                w_nxt_state = WBS_DEC_IDLE;
            end
            default: begin
                w_nxt_onehot = '0;
                w_nxt_state  = WBS_DEC_IDLE;
            end
        endcase
    end

    assign wbm_dat_o = r_rdat;
    assign wbm_ack_o = r_ack;
    assign wbm_err_o = r_err;
    assign wbs_cyc_o = r_onehot;
    assign wbs_stb_o = r_onehot;
    assign wbs_we_o  = r_we;
    assign wbs_sel_o = r_sel;
    assign wbs_adr_o = r_adr;
    assign wbs_dat_o = r_wdat;
    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_wbs_decoder.sv
// tb/tb_wbs_decoder.sv - directed self-checking bench for wbs_decoder
module tb_wbs_decoder;

    localparam logic [127:0] OVL_BASE = {32'h30000, 32'h20000, 32'h10000, 32'h10000};
    localparam logic [127:0] OVL_HIGH = {32'h3FFFF, 32'h2FFFF, 32'h1FFFF, 32'h1FFFF};

    logic        clk = 1'b0;
    logic        reset;
    logic        wbm_cyc_i, wbm_stb_i, wbm_we_i;
    logic [1:0]  wbm_sel_i;
    logic [31:0] wbm_adr_i;
    logic [15:0] wbm_dat_i;
    logic [63:0] wbs_dat_i;
    logic [3:0]  wbs_ack_i, wbs_err_i;

    logic [15:0] wbm_dat_o;
    logic        wbm_ack_o, wbm_err_o, timeout_o, wbs_we_o;
    logic [3:0]  wbs_cyc_o, wbs_stb_o;
    logic [1:0]  wbs_sel_o;
    logic [31:0] wbs_adr_o;
    logic [15:0] wbs_dat_o;

    logic [15:0] ov_dat_o;
    logic        ov_ack_o, ov_err_o, ov_timeout_o, ov_we_o;
    logic [3:0]  ov_cyc_o, ov_stb_o;
    logic [1:0]  ov_sel_o;
    logic [31:0] ov_adr_o;
    logic [15:0] ov_wdat_o;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int ack_base;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wbm_ack_o === 1'b1) ack_cnt++;
    end

    wbs_decoder #(.NUM_SLAVES(4), .TIMEOUT(16)) u_dut (
        .clk(clk), .reset(reset),
        .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
        .wbm_sel_i(wbm_sel_i), .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
        .wbs_sel_o(wbs_sel_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
        .timeout_o(timeout_o)
    );

    wbs_decoder #(.NUM_SLAVES(4), .SLAVE_BASE(OVL_BASE), .SLAVE_HIGH(OVL_HIGH), .TIMEOUT(16)) u_ovl (
        .clk(clk), .reset(reset),
        .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
        .wbm_sel_i(wbm_sel_i), .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i),
        .wbm_dat_o(ov_dat_o), .wbm_ack_o(ov_ack_o), .wbm_err_o(ov_err_o),
        .wbs_cyc_o(ov_cyc_o), .wbs_stb_o(ov_stb_o), .wbs_we_o(ov_we_o),
        .wbs_sel_o(ov_sel_o), .wbs_adr_o(ov_adr_o), .wbs_dat_o(ov_wdat_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
        .timeout_o(ov_timeout_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic master_idle();
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        wbm_we_i  = 1'b0;
        wbm_sel_i = 2'b00;
        wbm_adr_i = 32'h0;
        wbm_dat_i = 16'h0;
        wbs_ack_i = 4'b0000;
        wbs_err_i = 4'b0000;
    endtask

    task automatic master_req(input logic [31:0] adr, input logic we,
                              input logic [1:0] sel, input logic [15:0] dat);
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        wbm_we_i  = we;
        wbm_sel_i = sel;
        wbm_adr_i = adr;
        wbm_dat_i = dat;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_cyc"},  {60'h0, wbs_cyc_o}, 64'h0);
        check({pfx, "_stb"},  {60'h0, wbs_stb_o}, 64'h0);
        check({pfx, "_ack"},  {63'h0, wbm_ack_o}, 64'h0);
        check({pfx, "_err"},  {63'h0, wbm_err_o}, 64'h0);
        check({pfx, "_tmo"},  {63'h0, timeout_o}, 64'h0);
        check({pfx, "_rdat"}, {48'h0, wbm_dat_o}, 64'h0);
        check({pfx, "_adr"},  {32'h0, wbs_adr_o}, 64'h0);
        check({pfx, "_wdat"}, {48'h0, wbs_dat_o}, 64'h0);
        check({pfx, "_we"},   {63'h0, wbs_we_o},  64'h0);
        check({pfx, "_sel"},  {62'h0, wbs_sel_o}, 64'h0);
    endtask

    initial begin
        reset = 1'b1;
        wbs_dat_i = 64'h0;
        master_idle();
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Mapped write, slave 1 acks after its strobe has been up 3 cycles.
        ack_base = ack_cnt;
        master_req(32'h0001_0004, 1'b1, 2'b11, 16'h1234);
        tick();
        check("wr_stb",  {60'h0, wbs_stb_o}, 64'h2);
        check("wr_cyc",  {60'h0, wbs_cyc_o}, 64'h2);
        check("wr_adr",  {32'h0, wbs_adr_o}, 64'h4);
        check("wr_dat",  {48'h0, wbs_dat_o}, 64'h1234);
        check("wr_we",   {63'h0, wbs_we_o},  64'h1);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("wr_others", {60'h0, (wbs_stb_o & 4'b1101)}, 64'h0);
            check("wr_noack",  {63'h0, wbm_ack_o}, 64'h0);
        end
        wbs_ack_i = 4'b0010;
        tick();
        check("wr_ack",     {63'h0, wbm_ack_o}, 64'h1);
        check("wr_stb_drop", {60'h0, wbs_stb_o}, 64'h0);
        master_idle();
        tick();
        check("wr_ack_1cyc", {63'h0, wbm_ack_o}, 64'h0);
        tick();
        check("wr_ack_count", 64'(ack_cnt - ack_base), 64'h1);

        // Mapped read, slave 3 acks on the first cycle it sees stb.
        master_req(32'h0003_0010, 1'b0, 2'b11, 16'h0);
        tick();
        check("rd_stb",   {60'h0, wbs_stb_o}, 64'h8);
        check("rd_adr",   {32'h0, wbs_adr_o}, 64'h10);
        check("rd_ack_t", {63'h0, wbm_ack_o}, 64'h0);
        wbs_dat_i[63:48] = 16'hBEEF;
        wbs_ack_i = 4'b1000;
        tick();
        check("rd_ack_t1", {63'h0, wbm_ack_o}, 64'h1);
        check("rd_dat",    {48'h0, wbm_dat_o}, 64'hBEEF);
        master_idle();
        tick();
        tick();
        check("rd_dat_hold", {48'h0, wbm_dat_o}, 64'hBEEF);

        // Unmapped access.
        master_req(32'h0004_0000, 1'b0, 2'b11, 16'h0);
        tick();
        check("um_err", {63'h0, wbm_err_o}, 64'h1);
        check("um_cyc", {60'h0, wbs_cyc_o}, 64'h0);
        master_idle();
        tick();
        check("um_err_1cyc", {63'h0, wbm_err_o}, 64'h0);
        check("um_cyc2",     {60'h0, wbs_cyc_o}, 64'h0);
        tick();

        // Hung slave 2: error 16 cycles after its strobe rises.
        master_req(32'h0002_0000, 1'b0, 2'b11, 16'h0);
        tick();
        check("hung_stb", {60'h0, wbs_stb_o}, 64'h4);
        for (int k = 1; k < 16; k++) begin
            tick();
            check("hung_wait_err", {63'h0, wbm_err_o}, 64'h0);
            check("hung_wait_stb", {60'h0, wbs_stb_o}, 64'h4);
        end
        tick();
        check("hung_err",  {63'h0, wbm_err_o}, 64'h1);
        check("hung_tmo",  {63'h0, timeout_o}, 64'h1);
        check("hung_drop", {60'h0, wbs_stb_o}, 64'h0);
        master_idle();
        tick();
        check("hung_tmo_1cyc", {63'h0, timeout_o}, 64'h0);

        // Overlap and ack-over-err, from a clean state on both instances.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        master_req(32'h0001_0008, 1'b0, 2'b11, 16'h0);
        tick();
        check("ovl_stb",  {60'h0, ov_stb_o},  64'h1);
        check("ovl_adr",  {32'h0, ov_adr_o},  64'h8);
        check("dut_stb1", {60'h0, wbs_stb_o}, 64'h2);
        wbs_dat_i[15:0]  = 16'hA5A5;
        wbs_dat_i[31:16] = 16'h5A5A;
        wbs_ack_i = 4'b0011;
        wbs_err_i = 4'b0011;
        tick();
        check("ovl_ack",  {63'h0, ov_ack_o},  64'h1);
        check("ovl_err",  {63'h0, ov_err_o},  64'h0);
        check("ovl_dat",  {48'h0, ov_dat_o},  64'hA5A5);
        check("prec_ack", {63'h0, wbm_ack_o}, 64'h1);
        check("prec_err", {63'h0, wbm_err_o}, 64'h0);
        check("prec_dat", {48'h0, wbm_dat_o}, 64'h5A5A);
        master_idle();
        tick();
        tick();

        // Silent abort; also checks the base boundary rebases to 0.
        master_req(32'h0003_0000, 1'b0, 2'b11, 16'h0);
        tick();
        check("ab_stb", {60'h0, wbs_stb_o}, 64'h8);
        check("ab_adr", {32'h0, wbs_adr_o}, 64'h0);
        master_idle();
        tick();
        check("ab_drop", {60'h0, wbs_stb_o}, 64'h0);
        check("ab_ack",  {63'h0, wbm_ack_o}, 64'h0);
        check("ab_err",  {63'h0, wbm_err_o}, 64'h0);
        tick();
        check("ab_err2", {63'h0, wbm_err_o}, 64'h0);

        // Inclusive high boundary.
        master_req(32'h0002_FFFF, 1'b0, 2'b11, 16'h0);
        tick();
        check("hi_stb", {60'h0, wbs_stb_o}, 64'h4);
        check("hi_adr", {32'h0, wbs_adr_o}, 64'hFFFF);
        master_idle();
        tick();

        // Reset in BUSY, then a normal transaction.
        master_req(32'h0001_0000, 1'b1, 2'b01, 16'h7777);
        tick();
        check("rb_stb", {60'h0, wbs_stb_o}, 64'h2);
        check("rb_dat", {48'h0, wbs_dat_o}, 64'h7777);
        reset = 1'b1;
        tick();
        check_all_zero("rb_reset");
        reset = 1'b0;
        tick();
        check("rb_restart_stb", {60'h0, wbs_stb_o}, 64'h2);
        check("rb_restart_sel", {62'h0, wbs_sel_o}, 64'h1);
        wbs_dat_i[31:16] = 16'h0C0C;
        wbs_ack_i = 4'b0010;
        tick();
        check("rb_ack", {63'h0, wbm_ack_o}, 64'h1);
        check("rb_rd",  {48'h0, wbm_dat_o}, 64'h0C0C);
        master_idle();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
